// File: rtl/midi_voice_scheduler.sv
// midi_voice_scheduler
//
// Allocates MIDI note-on events to a fixed pool of sample-playback voices.
// Incoming events are buffered in a small FIFO. For each event, a small FSM
// scans the voices one per cycle. It then issues a one-cycle start pulse,
// together with the key and velocity, to the chosen voice.
//
// Voice selection priority:
//   1. a busy voice already playing the same key (retrigger)
//   2. the lowest-index free voice
//   3. the oldest busy voice (steal)
//
// Option 3 is only compiled in when MIDI_VOICE_STEAL_EN is defined. Without
// it, an event that finds no target is dropped and counted.
//
// Ports:
//   clk_100MHz      system clock
//   rst_n           synchronous active-low reset
//   midi_valid      one-cycle note-on strobe
//   midi_key        key of the strobed event (7 bits)
//   midi_velocity   velocity of the strobed event (7 bits); 0 = ignored
//   voice_done      per-voice end-of-sample pulse
//   voice_start     per-voice one-cycle start pulse
//   voice_key       latched key per voice, voice i at [7*i +: 7]
//   voice_velocity  latched velocity per voice, voice i at [7*i +: 7]
//   voice_busy      per-voice playing flag
//   dropped_count   saturating count of discarded events
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting; pops the FIFO head into the event register
//   ST_SCAN  | examines voice[scan_idx], one per cycle, tracking candidates
//   ST_ISSUE | starts the chosen voice (or drops the event), back to IDLE

module midi_voice_scheduler #(
   parameter int VOICE_COUNT = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int AGE_WIDTH   = 8
) (
   input  logic                     clk_100MHz,
   input  logic                     rst_n,
   input  logic                     midi_valid,
   input  logic [6:0]               midi_key,
   input  logic [6:0]               midi_velocity,
   input  logic [VOICE_COUNT-1:0]   voice_done,
   output logic [VOICE_COUNT-1:0]   voice_start,
   output logic [7*VOICE_COUNT-1:0] voice_key,
   output logic [7*VOICE_COUNT-1:0] voice_velocity,
   output logic [VOICE_COUNT-1:0]   voice_busy,
   output logic [7:0]               dropped_count
);

   localparam int IW = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

`ifdef MIDI_VOICE_STEAL_EN
   localparam bit STEAL_EN = 1'b1;
`else
   localparam bit STEAL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          scan_idx_q, scan_idx_d;
   logic [6:0]             ev_key_q, ev_key_d;
   logic [6:0]             ev_vel_q, ev_vel_d;

   logic                   match_valid_q, match_valid_d;
   logic [IW-1:0]          match_idx_q, match_idx_d;
   logic                   free_valid_q, free_valid_d;
   logic [IW-1:0]          free_idx_q, free_idx_d;
   logic                   old_valid_q, old_valid_d;
   logic [IW-1:0]          old_idx_q, old_idx_d;
   logic [AGE_WIDTH-1:0]   old_age_q, old_age_d;

   logic [13:0]            fifo_mem_q [FIFO_DEPTH];
   logic [13:0]            fifo_mem_d [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          fifo_count_q, fifo_count_d;

   logic [VOICE_COUNT-1:0] busy_q, busy_d;
   logic [6:0]             key_q [VOICE_COUNT];
   logic [6:0]             key_d [VOICE_COUNT];
   logic [6:0]             vel_q [VOICE_COUNT];
   logic [6:0]             vel_d [VOICE_COUNT];
   logic [AGE_WIDTH-1:0]   age_q [VOICE_COUNT];
   logic [AGE_WIDTH-1:0]   age_d [VOICE_COUNT];

   logic [7:0]             dropped_q, dropped_d;

   logic                   pop;
   logic                   push_req;
   logic                   push_ok;
   logic                   fifo_drop;
   logic                   issue_hit;
   logic                   issue_drop;
   logic [IW-1:0]          issue_idx;
   logic [VOICE_COUNT-1:0] start_vec;
   logic [8:0]             drop_sum;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d       = state_q;
      scan_idx_d    = scan_idx_q;
      ev_key_d      = ev_key_q;
      ev_vel_d      = ev_vel_q;
      match_valid_d = match_valid_q;
      match_idx_d   = match_idx_q;
      free_valid_d  = free_valid_q;
      free_idx_d    = free_idx_q;
      old_valid_d   = old_valid_q;
      old_idx_d     = old_idx_q;
      old_age_d     = old_age_q;
      pop           = 1'b0;
      issue_hit     = 1'b0;
      issue_drop    = 1'b0;
      issue_idx     = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (fifo_count_q != '0) begin
               pop                  = 1'b1;
               {ev_key_d, ev_vel_d} = fifo_mem_q[rd_ptr_q];
               scan_idx_d           = '0;
               match_valid_d        = 1'b0;
               match_idx_d          = '0;
               free_valid_d         = 1'b0;
               free_idx_d           = '0;
               old_valid_d          = 1'b0;
               old_idx_d            = '0;
               old_age_d            = '0;
               state_d              = ST_SCAN;
            end
         end

         ST_SCAN: begin
            // Busy is sampled live: a voice freed after its slot is missed.
            if (busy_q[scan_idx_q]) begin
               if (!match_valid_q && (key_q[scan_idx_q] == ev_key_q)) begin
                  match_valid_d = 1'b1;
                  match_idx_d   = scan_idx_q;
               end
               // Strict compare keeps the lowest index on equal ages.
               if (!old_valid_q || (age_q[scan_idx_q] > old_age_q)) begin
                  old_valid_d = 1'b1;
                  old_idx_d   = scan_idx_q;
                  old_age_d   = age_q[scan_idx_q];
               end
            end else if (!free_valid_q) begin
               free_valid_d = 1'b1;
               free_idx_d   = scan_idx_q;
            end

            if (scan_idx_q == IW'(VOICE_COUNT - 1)) begin
               state_d = ST_ISSUE;
            end else begin
               scan_idx_d = scan_idx_q + 1'b1;
            end
         end

         ST_ISSUE: begin
            state_d = ST_IDLE;
            if (match_valid_q) begin
               issue_hit = 1'b1;
               issue_idx = match_idx_q;
            end else if (free_valid_q) begin
               issue_hit = 1'b1;
               issue_idx = free_idx_q;
            end else if (STEAL_EN && old_valid_q) begin
               issue_hit = 1'b1;
               issue_idx = old_idx_q;
            end else begin
               issue_drop = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- FIFO
   always_comb begin
      push_req     = midi_valid && (midi_velocity != 7'd0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_ok      = push_req && ((fifo_count_q != CW'(FIFO_DEPTH)) || pop);
      fifo_drop    = push_req && !push_ok;

      fifo_mem_d   = fifo_mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_count_d = fifo_count_q + CW'(push_ok) - CW'(pop);

      if (push_ok) begin
         fifo_mem_d[wr_ptr_q] = {midi_key, midi_velocity};
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // ------------------------------------------------------------- voices
   always_comb begin
      start_vec = '0;
      busy_d    = busy_q;
      for (int i = 0; i < VOICE_COUNT; i++) begin
         key_d[i] = key_q[i];
         vel_d[i] = vel_q[i];
         age_d[i] = age_q[i];

         start_vec[i] = issue_hit && (issue_idx == IW'(i));

         // A start coinciding with done keeps the voice busy.
         if (start_vec[i]) begin
            busy_d[i] = 1'b1;
         end else if (voice_done[i]) begin
            busy_d[i] = 1'b0;
         end

         if (start_vec[i]) begin
            key_d[i] = ev_key_q;
            vel_d[i] = ev_vel_q;
            age_d[i] = '0;
         end else if (issue_hit && busy_q[i] && (age_q[i] != '1)) begin
            age_d[i] = age_q[i] + 1'b1;
         end
      end
   end

   // ---------------------------------------------------- dropped counter
   always_comb begin
      // FIFO overflow and a targetless issue can land in the same cycle.
      drop_sum = {1'b0, dropped_q} + 9'(fifo_drop) + 9'(issue_drop);
      if (drop_sum > 9'd255) begin
         dropped_d = 8'hFF;
      end else begin
         dropped_d = drop_sum[7:0];
      end
   end

   // ------------------------------------------------------------ outputs
   always_comb begin
      voice_key      = '0;
      voice_velocity = '0;
      for (int i = 0; i < VOICE_COUNT; i++) begin
         voice_key[7*i +: 7]      = key_q[i];
         voice_velocity[7*i +: 7] = vel_q[i];
      end
   end

   assign voice_start   = start_vec;
   assign voice_busy    = busy_q;
   assign dropped_count = dropped_q;

   // ---------------------------------------------------------- registers
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         scan_idx_q    <= '0;
         ev_key_q      <= '0;
         ev_vel_q      <= '0;
         match_valid_q <= 1'b0;
         match_idx_q   <= '0;
         free_valid_q  <= 1'b0;
         free_idx_q    <= '0;
         old_valid_q   <= 1'b0;
         old_idx_q     <= '0;
         old_age_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_count_q  <= '0;
         busy_q        <= '0;
         dropped_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         for (int i = 0; i < VOICE_COUNT; i++) begin
            key_q[i] <= '0;
            vel_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         scan_idx_q    <= scan_idx_d;
         ev_key_q      <= ev_key_d;
         ev_vel_q      <= ev_vel_d;
         match_valid_q <= match_valid_d;
         match_idx_q   <= match_idx_d;
         free_valid_q  <= free_valid_d;
         free_idx_q    <= free_idx_d;
         old_valid_q   <= old_valid_d;
         old_idx_q     <= old_idx_d;
         old_age_q     <= old_age_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_count_q  <= fifo_count_d;
         busy_q        <= busy_d;
         dropped_q     <= dropped_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= fifo_mem_d[i];
         end
         for (int i = 0; i < VOICE_COUNT; i++) begin
            key_q[i] <= key_d[i];
            vel_q[i] <= vel_d[i];
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: tb/tb_midi_voice_scheduler.sv
// Directed testbench for midi_voice_scheduler (default parameters).
// Expects the build without MIDI_VOICE_STEAL_EN unless that macro is defined
// for this file as well.

module tb_midi_voice_scheduler;

   logic        clk_100MHz;
   logic        rst_n;
   logic        midi_valid;
   logic [6:0]  midi_key;
   logic [6:0]  midi_velocity;
   logic [3:0]  voice_done;
   logic [3:0]  voice_start;
   logic [27:0] voice_key;
   logic [27:0] voice_velocity;
   logic [3:0]  voice_busy;
   logic [7:0]  dropped_count;

   int checks   = 0;
   int failures = 0;

   midi_voice_scheduler #(
      .VOICE_COUNT (4),
      .FIFO_DEPTH  (4),
      .AGE_WIDTH   (8)
   ) dut (
      .clk_100MHz     (clk_100MHz),
      .rst_n          (rst_n),
      .midi_valid     (midi_valid),
      .midi_key       (midi_key),
      .midi_velocity  (midi_velocity),
      .voice_done     (voice_done),
      .voice_start    (voice_start),
      .voice_key      (voice_key),
      .voice_velocity (voice_velocity),
      .voice_busy     (voice_busy),
      .dropped_count  (dropped_count)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk_100MHz);
      rst_n         = 1'b0;
      midi_valid    = 1'b0;
      midi_key      = '0;
      midi_velocity = '0;
      voice_done    = '0;
      repeat (2) @(negedge clk_100MHz);
      rst_n = 1'b1;
   endtask

   // Strobe one event in cycle 0; returns at the falling edge of cycle 1.
   task automatic send(input logic [6:0] key, input logic [6:0] vel);
      @(negedge clk_100MHz);
      midi_valid    = 1'b1;
      midi_key      = key;
      midi_velocity = vel;
      @(negedge clk_100MHz);
      midi_valid    = 1'b0;
   endtask

   // Advances falling edges until a start pulse appears or the cycle limit.
   task automatic wait_start(input int first_cycle, input int limit,
                             output int cyc, output logic [3:0] vec);
      cyc = first_cycle;
      vec = voice_start;
      while (vec == 4'b0 && cyc < limit) begin
         @(negedge clk_100MHz);
         cyc++;
         vec = voice_start;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk_100MHz);
      checks++;
      if (voice_start !== 4'b0) begin
         failures++; $display("FAIL reset_start: got %b expected 0000", voice_start);
      end
      checks++;
      if (voice_key !== 28'h0) begin
         failures++; $display("FAIL reset_key: got %h expected 0", voice_key);
      end
      checks++;
      if (voice_velocity !== 28'h0) begin
         failures++; $display("FAIL reset_vel: got %h expected 0", voice_velocity);
      end
      checks++;
      if (voice_busy !== 4'b0) begin
         failures++; $display("FAIL reset_busy: got %b expected 0000", voice_busy);
      end
      checks++;
      if (dropped_count !== 8'd0) begin
         failures++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count);
      end
   endtask

   task automatic test_first_note();
      int         cyc;
      logic [3:0] vec;
      send(7'd36, 7'd100);
      wait_start(1, 20, cyc, vec);
      checks++;
      if (cyc != 6) begin
         failures++; $display("FAIL first_latency: got cycle %0d expected 6", cyc);
      end
      checks++;
      if (vec !== 4'b0001) begin
         failures++; $display("FAIL first_target: got %b expected 0001", vec);
      end
      @(negedge clk_100MHz);
      checks++;
      if (voice_start !== 4'b0) begin
         failures++; $display("FAIL first_pulse_width: got %b expected 0000", voice_start);
      end
      checks++;
      if (voice_key[6:0] !== 7'd36) begin
         failures++; $display("FAIL first_key: got %0d expected 36", voice_key[6:0]);
      end
      checks++;
      if (voice_velocity[6:0] !== 7'd100) begin
         failures++; $display("FAIL first_vel: got %0d expected 100", voice_velocity[6:0]);
      end
      checks++;
      if (voice_busy !== 4'b0001) begin
         failures++; $display("FAIL first_busy: got %b expected 0001", voice_busy);
      end
   endtask

   task automatic test_retrigger();
      int         cyc;
      logic [3:0] vec;
      send(7'd36, 7'd50);
      wait_start(1, 20, cyc, vec);
      checks++;
      if (vec !== 4'b0001 || cyc != 6) begin
         failures++; $display("FAIL retrig_target: got %b at cycle %0d expected 0001 at 6", vec, cyc);
      end
      @(negedge clk_100MHz);
      checks++;
      if (voice_velocity[6:0] !== 7'd50) begin
         failures++; $display("FAIL retrig_vel: got %0d expected 50", voice_velocity[6:0]);
      end
      checks++;
      if (voice_busy !== 4'b0001) begin
         failures++; $display("FAIL retrig_busy: got %b expected 0001", voice_busy);
      end
   endtask

   task automatic test_fill_steal();
      int         cyc;
      logic [3:0] vec;
      logic [6:0] keys [4];
      logic [3:0] exp_vec [4];
      keys    = '{7'd36, 7'd38, 7'd46, 7'd42};
      exp_vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      do_reset();
      for (int n = 0; n < 4; n++) begin
         send(keys[n], 7'd90);
         wait_start(1, 20, cyc, vec);
         checks++;
         if (vec !== exp_vec[n]) begin
            failures++; $display("FAIL fill_target%0d: got %b expected %b", n, vec, exp_vec[n]);
         end
         @(negedge clk_100MHz);
      end
      checks++;
      if (voice_busy !== 4'b1111) begin
         failures++; $display("FAIL fill_busy: got %b expected 1111", voice_busy);
      end
      send(7'd49, 7'd90);
`ifdef MIDI_VOICE_STEAL_EN
      wait_start(1, 20, cyc, vec);
      checks++;
      if (vec !== 4'b0001) begin
         failures++; $display("FAIL steal_target: got %b expected 0001", vec);
      end
      @(negedge clk_100MHz);
      checks++;
      if (voice_key[6:0] !== 7'd49) begin
         failures++; $display("FAIL steal_key: got %0d expected 49", voice_key[6:0]);
      end
      checks++;
      if (dropped_count !== 8'd0 || voice_busy !== 4'b1111) begin
         failures++; $display("FAIL steal_state: got dropped %0d busy %b expected 0 1111", dropped_count, voice_busy);
      end
`else
      wait_start(1, 12, cyc, vec);
      checks++;
      if (vec !== 4'b0000) begin
         failures++; $display("FAIL nosteal_pulse: got %b expected 0000", vec);
      end
      checks++;
      if (dropped_count !== 8'd1) begin
         failures++; $display("FAIL nosteal_dropped: got %0d expected 1", dropped_count);
      end
      checks++;
      if (voice_key[6:0] !== 7'd36) begin
         failures++; $display("FAIL nosteal_key: got %0d expected 36", voice_key[6:0]);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int         pulses;
      int         exp_pulses;
      logic [7:0] exp_drop;
      logic [3:0] busy_before;
      do_reset();
      pulses = 0;
      @(negedge clk_100MHz);
      for (int n = 0; n < 6; n++) begin
         midi_valid    = 1'b1;
         midi_key      = 7'(60 + n);
         midi_velocity = 7'd64;
         pulses += $countones(voice_start);
         @(negedge clk_100MHz);
      end
      midi_valid = 1'b0;
      for (int n = 0; n < 60; n++) begin
         pulses += $countones(voice_start);
         @(negedge clk_100MHz);
      end
`ifdef MIDI_VOICE_STEAL_EN
      exp_pulses = 5;
      exp_drop   = 8'd1;
`else
      exp_pulses = 4;
      exp_drop   = 8'd2;
`endif
      checks++;
      if (pulses != exp_pulses) begin
         failures++; $display("FAIL b2b_pulses: got %0d expected %0d", pulses, exp_pulses);
      end
      checks++;
      if (dropped_count !== exp_drop) begin
         failures++; $display("FAIL b2b_dropped: got %0d expected %0d", dropped_count, exp_drop);
      end
      busy_before = voice_busy;
      send(7'd70, 7'd0);
      pulses = 0;
      for (int n = 0; n < 12; n++) begin
         pulses += $countones(voice_start);
         @(negedge clk_100MHz);
      end
      checks++;
      if (pulses != 0 || dropped_count !== exp_drop) begin
         failures++; $display("FAIL vel0_ignored: got pulses %0d dropped %0d expected 0 and %0d", pulses, dropped_count, exp_drop);
      end
      checks++;
      if (voice_busy !== 4'b1111 || busy_before !== 4'b1111) begin
         failures++; $display("FAIL vel0_busy: got %b then %b expected 1111", busy_before, voice_busy);
      end
   endtask

   task automatic test_done_collision();
      int         cyc;
      logic [3:0] vec;
      logic [6:0] keys [3];
      keys = '{7'd36, 7'd38, 7'd46};
      do_reset();
      for (int n = 0; n < 3; n++) begin
         send(keys[n], 7'd90);
         wait_start(1, 20, cyc, vec);
         @(negedge clk_100MHz);
      end
      checks++;
      if (voice_busy !== 4'b0111) begin
         failures++; $display("FAIL coll_setup_busy: got %b expected 0111", voice_busy);
      end
      send(7'd36, 7'd80);
      wait_start(1, 20, cyc, vec);
      checks++;
      if (vec !== 4'b0001 || cyc != 6) begin
         failures++; $display("FAIL coll_target: got %b at cycle %0d expected 0001 at 6", vec, cyc);
      end
      voice_done = 4'b0001;
      @(negedge clk_100MHz);
      voice_done = 4'b0000;
      checks++;
      if (voice_busy !== 4'b0111) begin
         failures++; $display("FAIL coll_busy: got %b expected 0111", voice_busy);
      end
      checks++;
      if (voice_velocity[6:0] !== 7'd80) begin
         failures++; $display("FAIL coll_vel: got %0d expected 80", voice_velocity[6:0]);
      end
      voice_done = 4'b0100;
      @(negedge clk_100MHz);
      voice_done = 4'b0000;
      checks++;
      if (voice_busy !== 4'b0011) begin
         failures++; $display("FAIL done2_busy: got %b expected 0011", voice_busy);
      end
   endtask

   task automatic test_reset_mid_scan();
      int         pulses;
      int         cyc;
      logic [3:0] vec;
      do_reset();
      @(negedge clk_100MHz);
      for (int n = 0; n < 3; n++) begin
         midi_valid    = 1'b1;
         midi_key      = 7'(50 + n);
         midi_velocity = 7'd77;
         @(negedge clk_100MHz);
      end
      // Cycle 3: FSM is scanning with two events queued behind it.
      midi_valid = 1'b0;
      rst_n      = 1'b0;
      @(negedge clk_100MHz);
      rst_n  = 1'b1;
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         pulses += $countones(voice_start);
         @(negedge clk_100MHz);
      end
      checks++;
      if (pulses != 0) begin
         failures++; $display("FAIL rst_scan_pulses: got %0d expected 0", pulses);
      end
      checks++;
      if (voice_busy !== 4'b0 || voice_key !== 28'h0 || voice_velocity !== 28'h0 || dropped_count !== 8'd0) begin
         failures++; $display("FAIL rst_scan_state: got busy %b key %h vel %h dropped %0d expected all 0", voice_busy, voice_key, voice_velocity, dropped_count);
      end
      send(7'd40, 7'd20);
      wait_start(1, 20, cyc, vec);
      checks++;
      if (vec !== 4'b0001 || cyc != 6) begin
         failures++; $display("FAIL rst_scan_resume: got %b at cycle %0d expected 0001 at 6", vec, cyc);
      end
      @(negedge clk_100MHz);
      checks++;
      if (voice_key[6:0] !== 7'd40) begin
         failures++; $display("FAIL rst_scan_key: got %0d expected 40 (stale queued event?)", voice_key[6:0]);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      midi_valid    = 1'b0;
      midi_key      = '0;
      midi_velocity = '0;
      voice_done    = '0;
      test_reset();
      test_first_note();
      test_retrigger();
      test_fill_steal();
      test_back_to_back();
      test_done_collision();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
